// File: rtl/captura_pkg.sv
// Shared definitions for the pixel capture controller: state encoding and
// default frame geometry.
package captura_pkg;

  localparam int LARGURA_PADRAO = 160;
  localparam int ALTURA_PADRAO  = 120;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_VSYNC  = 3'd1,
    ESPERA_INICIO = 3'd2,
    CAPTURA       = 3'd3,
    FIM           = 3'd4
  } estado_t;

endpackage

// File: rtl/contador_xy.sv
// x/y position and linear frame-buffer address counter. The line start
// address is kept as a running sum so no multiplier is needed.
module contador_xy #(
  parameter int LARGURA = 160,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zerar_i,      // start of frame: everything to 0
  input  logic              incrementa_i, // a pixel was written this cycle
  input  logic              fim_linha_i,  // href falling edge
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] endereco_o
);

  localparam logic [ADDR_W-1:0] PASSO_LINHA = ADDR_W'(LARGURA);

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] endereco_q;
  logic [ADDR_W-1:0] base_q;      // address of x=0 on the current line
  logic              tem_pixel_q; // at least one pixel written on this line

  // Position counters; a line only advances y if it produced a pixel.
  // A pixel written in the same cycle as the line end still counts.
  always_ff @(posedge clock) begin
    if (reset || zerar_i) begin
      x_q         <= '0;
      y_q         <= '0;
      endereco_q  <= '0;
      base_q      <= '0;
      tem_pixel_q <= 1'b0;
    end else if (fim_linha_i) begin
      if (tem_pixel_q || incrementa_i) begin
        x_q        <= '0;
        y_q        <= y_q + Y_W'(1);
        base_q     <= base_q + PASSO_LINHA;
        endereco_q <= base_q + PASSO_LINHA;
      end
      tem_pixel_q <= 1'b0;
    end else if (incrementa_i) begin
      x_q         <= x_q + X_W'(1);
      endereco_q  <= endereco_q + ADDR_W'(1);
      tem_pixel_q <= 1'b1;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign endereco_o = endereco_q;

endmodule

// File: rtl/controle_captura_pixel.sv
// Control unit for camera frame capture: pairs accepted bytes into RGB565
// pixels, drives the pixel register and emits write strobes and addresses.
module controle_captura_pixel
  import captura_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int ALTURA  = ALTURA_PADRAO,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              vsync,
  input  logic              href,
  input  logic              byte_valido,
  output logic              enable_pixel,
  output logic              clear_pixel,
  output logic              pixel_pronto,
  output logic [ADDR_W-1:0] endereco,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              ocupado,
  output logic              quadro_pronto,
  output logic              erro_linha,
  output logic [2:0]        db_estado
);

  localparam logic [X_W-1:0] X_LIMITE = X_W'(LARGURA);
  localparam logic [X_W-1:0] X_ULTIMO = X_W'(LARGURA - 1);
  localparam logic [Y_W-1:0] Y_LIMITE = Y_W'(ALTURA);
  localparam logic [Y_W-1:0] Y_ULTIMO = Y_W'(ALTURA - 1);

  estado_t estado_q;
  logic    fase_q;          // 1 = first byte of a pixel already taken
  logic    href_q;
  logic    clear_pixel_q;
  logic    pixel_pronto_q;
  logic    quadro_pronto_q;
  logic    erro_linha_q;

  logic              captura_s;
  logic              aceita_s;
  logic              completa_s;
  logic              fim_linha_s;
  logic              inicio_s;
  logic              ultimo_s;
  logic [X_W-1:0]    x_s;
  logic [Y_W-1:0]    y_s;
  logic [ADDR_W-1:0] endereco_s;

  assign captura_s   = (estado_q == CAPTURA);
  assign aceita_s    = captura_s && byte_valido && href && (y_s < Y_LIMITE);
  // Second byte of a pair; bytes past the end of the line pair up but are dropped.
  assign completa_s  = aceita_s && fase_q && (x_s < X_LIMITE);
  assign fim_linha_s = captura_s && href_q && !href;
  assign inicio_s    = (estado_q == ESPERA_INICIO) && !vsync;
  assign ultimo_s    = captura_s && pixel_pronto_q &&
                       (x_s == X_ULTIMO) && (y_s == Y_ULTIMO);

  contador_xy #(
    .LARGURA (LARGURA),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .ADDR_W  (ADDR_W)
  ) u_contador_xy (
    .clock        (clock),
    .reset        (reset),
    .zerar_i      (inicio_s),
    .incrementa_i (pixel_pronto_q),
    .fim_linha_i  (fim_linha_s),
    .x_o          (x_s),
    .y_o          (y_s),
    .endereco_o   (endereco_s)
  );

  // Capture FSM with byte-phase tracking and registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      fase_q          <= 1'b0;
      href_q          <= 1'b0;
      clear_pixel_q   <= 1'b0;
      pixel_pronto_q  <= 1'b0;
      quadro_pronto_q <= 1'b0;
      erro_linha_q    <= 1'b0;
    end else begin
      href_q          <= href;
      clear_pixel_q   <= 1'b0;
      quadro_pronto_q <= 1'b0;
      pixel_pronto_q  <= completa_s;
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            estado_q     <= ESPERA_VSYNC;
            erro_linha_q <= 1'b0;
          end
        end
        ESPERA_VSYNC: begin
          if (vsync) begin
            estado_q <= ESPERA_INICIO;
          end
        end
        ESPERA_INICIO: begin
          if (!vsync) begin
            estado_q      <= CAPTURA;
            fase_q        <= 1'b0;
            clear_pixel_q <= 1'b1;
          end
        end
        CAPTURA: begin
          if (aceita_s) begin
            fase_q <= ~fase_q;
          end else if (fim_linha_s) begin
            if (fase_q) begin
              erro_linha_q <= 1'b1;
            end
            fase_q <= 1'b0;
          end
          if (vsync || ultimo_s) begin
            estado_q        <= FIM;
            quadro_pronto_q <= 1'b1;
          end
        end
        FIM: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign enable_pixel  = aceita_s;
  assign clear_pixel   = clear_pixel_q;
  assign pixel_pronto  = pixel_pronto_q;
  assign quadro_pronto = quadro_pronto_q;
  assign erro_linha    = erro_linha_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign db_estado     = estado_q;
  assign x             = x_s;
  assign y             = y_s;
  assign endereco      = endereco_s;

endmodule

// File: tb/tb_controle_captura_pixel.sv
// Self-checking bench for controle_captura_pixel with a 4x2 frame.
module tb_controle_captura_pixel;

  localparam int L  = 4;
  localparam int A  = 2;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset, iniciar, vsync, href, byte_valido;
  logic [7:0]    d;
  logic          enable_pixel, clear_pixel, pixel_pronto, ocupado;
  logic          quadro_pronto, erro_linha;
  logic [AW-1:0] endereco;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    db_estado;

  int tests = 0;
  int fails = 0;

  // Expected writes from the frame model, and what the DUT actually wrote.
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  int          log_addr[$];
  logic [15:0] log_data[$];
  int          qp_count = 0;
  int          model_y;
  logic        model_erro;
  logic [15:0] q_reg = 16'h0000;   // stand-in for registrador_pixel
  int          ea;
  logic [15:0] ed;

  controle_captura_pixel #(
    .LARGURA (L), .ALTURA (A), .X_W (XW), .Y_W (YW), .ADDR_W (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .vsync         (vsync),
    .href          (href),
    .byte_valido   (byte_valido),
    .enable_pixel  (enable_pixel),
    .clear_pixel   (clear_pixel),
    .pixel_pronto  (pixel_pronto),
    .endereco      (endereco),
    .x             (x),
    .y             (y),
    .ocupado       (ocupado),
    .quadro_pronto (quadro_pronto),
    .erro_linha    (erro_linha),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  task automatic check(input string nome, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nome, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare process: every write strobe against the model, plus per-cycle rules.
  always @(negedge clock) begin
    if (pixel_pronto) begin
      log_addr.push_back(int'(endereco));
      log_data.push_back(q_reg);
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pixel_inesperado: got write at %0d, required none", endereco);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("pixel_endereco", endereco, ea);
        check("pixel_dado", q_reg, ed);
        check("pixel_x", x, ea % L);
        check("pixel_y", y, ea / L);
      end
    end
    if (quadro_pronto) begin
      qp_count++;
      check("quadro_pendentes", exp_addr.size(), 0);
    end
    check("ocupado_vs_estado", ocupado, db_estado != 3'd0);
    if (!ocupado) check("enable_ocioso", enable_pixel, 0);
    if (clear_pixel) q_reg <= 16'h0000;
    else if (enable_pixel) q_reg <= {q_reg[7:0], d};
  end

  // Frame model: a line of n bytes yields min(n/2, L) pixels at y*L + i.
  task automatic model_line(input int nbytes, input int b0);
    int npix;
    npix = nbytes / 2;
    if (npix > L) npix = L;
    if (model_y < A) begin
      for (int i = 0; i < npix; i++) begin
        exp_addr.push_back(model_y * L + i);
        exp_data.push_back({8'(b0 + 2 * i), 8'(b0 + 2 * i + 1)});
      end
      if (npix > 0) model_y++;
    end
    if (nbytes % 2 != 0) model_erro = 1'b1;
  endtask

  task automatic send_line(input int nbytes, input int b0);
    model_line(nbytes, b0);
    href = 1'b1;
    tick();
    for (int j = 0; j < nbytes; j++) begin
      d = 8'(b0 + j);
      byte_valido = 1'b1;
      tick();
      byte_valido = 1'b0;
      tick();
    end
    href = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic start_frame();
    model_y    = 0;
    model_erro = 1'b0;
    log_addr.delete();
    log_data.delete();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("estado_espera_vsync", db_estado, 1);
    check("erro_limpo_iniciar", erro_linha, 0);
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick();
    check("estado_captura", db_estado, 3);
    check("clear_pulso", clear_pixel, 1);
    check("endereco_inicio", endereco, 0);
    tick();
  endtask

  task automatic end_frame_vsync();
    vsync = 1'b1;
    tick();
    check("estado_fim", db_estado, 4);
    check("quadro_pronto_fim", quadro_pronto, 1);
    tick();
    check("estado_ocioso_apos_fim", db_estado, 0);
  endtask

  task automatic wait_ocioso();
    int n;
    n = 0;
    while (db_estado != 3'd0 && n < 20) begin
      tick();
      n++;
    end
    check("espera_ocioso_timeout", n < 20, 1);
  endtask

  int qp0;

  initial begin
    reset = 1'b1; iniciar = 1'b0; vsync = 1'b0; href = 1'b0;
    byte_valido = 1'b0; d = 8'h00;
    tick();
    reset = 1'b0;

    // Reset state, including a byte strobe while idle.
    check("reset_estado", db_estado, 0);
    check("reset_pixel_pronto", pixel_pronto, 0);
    check("reset_clear", clear_pixel, 0);
    check("reset_quadro", quadro_pronto, 0);
    check("reset_erro", erro_linha, 0);
    check("reset_ocupado", ocupado, 0);
    check("reset_xy_end", {x, y, endereco}, 0);
    href = 1'b1; byte_valido = 1'b1; d = 8'hAA;
    #1;
    check("reset_enable", enable_pixel, 0);
    tick();
    href = 1'b0; byte_valido = 1'b0;
    tick();

    // Full frame: 2 lines of bytes 0x00..0x0F.
    qp0 = qp_count;
    start_frame();
    send_line(8, 8'h00);
    send_line(8, 8'h08);
    wait_ocioso();
    check("cheio_n_pixels", log_addr.size(), 8);
    check("cheio_p0_dado", log_data[0], 16'h0001);
    check("cheio_p0_end", log_addr[0], 0);
    check("cheio_p7_dado", log_data[7], 16'h0E0F);
    check("cheio_p7_end", log_addr[7], 7);
    check("cheio_quadros", qp_count - qp0, 1);
    check("cheio_erro", erro_linha, 0);

    // Odd line followed by a correct line.
    start_frame();
    send_line(7, 8'h00);
    check("impar_erro_modelo", erro_linha, model_erro);
    check("impar_erro", erro_linha, 1);
    send_line(8, 8'h10);
    wait_ocioso();
    check("impar_n_pixels", log_addr.size(), 7);
    check("impar_p2_dado", log_data[2], 16'h0405);
    check("impar_p3_end", log_addr[3], 4);
    check("impar_p3_dado", log_data[3], 16'h1011);
    check("impar_erro_sticky", erro_linha, 1);

    // Overrun line, ignored iniciar, then early vsync after 3 pixels.
    qp0 = qp_count;
    start_frame();
    send_line(10, 8'h30);
    check("overrun_n_pixels", log_addr.size(), 4);
    check("overrun_y", y, 1);
    check("overrun_endereco", endereco, 4);
    check("overrun_p3_dado", log_data[3], 16'h3637);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("iniciar_ignorado", db_estado, 3);
    send_line(6, 8'h40);
    check("precoce_n_pixels", log_addr.size(), 7);
    end_frame_vsync();
    check("precoce_quadros", qp_count - qp0, 1);

    // vsync rising together with the second byte of a pixel.
    start_frame();
    model_line(2, 8'h50);
    href = 1'b1;
    d = 8'h50; byte_valido = 1'b1; tick();
    byte_valido = 1'b0; tick();
    d = 8'h51; byte_valido = 1'b1; vsync = 1'b1; tick();
    byte_valido = 1'b0; href = 1'b0;
    check("vsync_byte_estado", db_estado, 4);
    check("vsync_byte_pixel", pixel_pronto, 1);
    check("vsync_byte_quadro", quadro_pronto, 1);
    tick();
    check("vsync_byte_ocioso", db_estado, 0);
    check("vsync_byte_dado", log_data[0], 16'h5051);

    // Reset in the middle of a line, then a clean frame.
    qp0 = qp_count;
    start_frame();
    href = 1'b1;
    d = 8'h55; byte_valido = 1'b1; tick();
    byte_valido = 1'b0; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    check("rst_meio_estado", db_estado, 0);
    check("rst_meio_pixel", pixel_pronto, 0);
    check("rst_meio_quadro", quadro_pronto, 0);
    href = 1'b0;
    tick();
    check("rst_meio_sem_quadro", qp_count - qp0, 0);
    start_frame();
    send_line(8, 8'h20);
    end_frame_vsync();
    check("rst_p0_end", log_addr[0], 0);
    check("rst_p0_dado", log_data[0], 16'h2021);
    check("fila_final", exp_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
